// File: rtl/output_error_unit.sv
// Output-layer error stage with a shared fixed-point arithmetic library.
//
// output_error_pkg : sfp fixed-point type (signed Q8.8, saturating), act_func
//                    activation encoding, and the sfp_add/sfp_neg/sfp_mul helpers.
//
// output_error_unit: takes one sample (predictions, pre-activation sums, targets),
//                    then walks the output lanes one per cycle through a single
//                    arithmetic path to produce dL/dsum per lane, and accumulates
//                    a saturating batch sum of squared errors.
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   in_valid / in_ready   sample handshake; activation and data captured on accept
//   activation            output-layer activation function
//   predictions, sums,    per-lane sfp inputs
//   targets
//   out_valid / out_ready gradient handshake; error_gradient stable while out_valid
//   error_gradient        per-lane output gradients
//   loss_valid, loss      one-cycle pulse when loss takes a completed batch's sum
//   sample_count          samples completed in the current batch

package output_error_pkg;
    localparam int SFP_W    = 16;
    localparam int SFP_FRAC = 8;

    typedef logic signed [SFP_W-1:0] sfp;

    localparam sfp SFP_MAX = 16'sh7fff;
    localparam sfp SFP_MIN = 16'sh8000;
    localparam sfp SFP_ONE = 16'sh0100;

    typedef enum logic [1:0] {
        ACT_LINEAR  = 2'd0,
        ACT_SIGMOID = 2'd1,
        ACT_TANH    = 2'd2,
        ACT_RELU    = 2'd3
    } act_func;

    function automatic sfp sfp_sat(input logic signed [31:0] v);
        sfp r;
        if (v > 32'sd32767) begin
            r = SFP_MAX;
        end else if (v < -32'sd32768) begin
            r = SFP_MIN;
        end else begin
            r = v[SFP_W-1:0];
        end
        return r;
    endfunction

    function automatic sfp sfp_add(input sfp a, input sfp b);
        logic signed [31:0] aw;
        logic signed [31:0] bw;
        aw = a;
        bw = b;
        return sfp_sat(aw + bw);
    endfunction

    // Negating the most negative value saturates instead of wrapping.
    function automatic sfp sfp_neg(input sfp a);
        logic signed [31:0] aw;
        aw = a;
        return sfp_sat(-aw);
    endfunction

    // Product is truncated toward minus infinity (arithmetic shift), then saturated.
    function automatic sfp sfp_mul(input sfp a, input sfp b);
        logic signed [31:0] aw;
        logic signed [31:0] bw;
        logic signed [31:0] pr;
        aw = a;
        bw = b;
        pr = aw * bw;
        return sfp_sat(pr >>> SFP_FRAC);
    endfunction
endpackage

module output_error_unit
    import output_error_pkg::*;
#(
    parameter int output_units = 2,
    parameter int batch_size   = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  act_func                           activation,
    input  sfp [output_units-1:0]             predictions,
    input  sfp [output_units-1:0]             sums,
    input  sfp [output_units-1:0]             targets,
    output logic                              out_valid,
    input  logic                              out_ready,
    output sfp [output_units-1:0]             error_gradient,
    output logic                              loss_valid,
    output sfp                                loss,
    output logic [$clog2(batch_size+1)-1:0]   sample_count
);
    localparam int KW = (output_units > 1) ? $clog2(output_units) : 1;
    localparam int CW = $clog2(batch_size + 1);

    typedef enum logic [1:0] {IDLE, COMPUTE, HOLD} state_t;

    state_t                 state_q, state_d;
    logic [KW-1:0]          k_q, k_d;
    act_func                act_q, act_d;
    sfp [output_units-1:0]  pred_q, pred_d;
    sfp [output_units-1:0]  sum_q, sum_d;
    sfp [output_units-1:0]  tgt_q, tgt_d;
    sfp [output_units-1:0]  grad_q, grad_d;
    sfp                     acc_q, acc_d;
    sfp                     loss_q, loss_d;
    logic                   loss_valid_q, loss_valid_d;
    logic [CW-1:0]          count_q, count_d;

    // Single lane datapath, steered by k_q.
    sfp lane_p, lane_t, lane_s, lane_e, lane_g, lane_sq;

    always_comb begin
        lane_p  = pred_q[k_q];
        lane_t  = tgt_q[k_q];
        lane_s  = sum_q[k_q];
        lane_e  = sfp_add(lane_p, sfp_neg(lane_t));
        lane_sq = sfp_mul(lane_e, lane_e);
        case (act_q)
            ACT_SIGMOID: lane_g = sfp_mul(sfp_mul(lane_e, lane_p),
                                          sfp_add(SFP_ONE, sfp_neg(lane_p)));
            ACT_TANH:    lane_g = sfp_mul(lane_e,
                                          sfp_add(SFP_ONE, sfp_neg(sfp_mul(lane_p, lane_p))));
            ACT_RELU:    lane_g = (lane_s >= sfp'(0)) ? lane_e : sfp'(0);
            default:     lane_g = lane_e;
        endcase
    end

    // Only the lane currently being processed updates; all others hold.
    for (genvar gi = 0; gi < output_units; gi++) begin : g_lane
        assign grad_d[gi] = (state_q == COMPUTE && k_q == KW'(gi)) ? lane_g : grad_q[gi];
    end

    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        act_d        = act_q;
        pred_d       = pred_q;
        sum_d        = sum_q;
        tgt_d        = tgt_q;
        acc_d        = acc_q;
        loss_d       = loss_q;
        loss_valid_d = 1'b0;
        count_d      = count_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    act_d   = activation;
                    pred_d  = predictions;
                    sum_d   = sums;
                    tgt_d   = targets;
                    k_d     = '0;
                    state_d = COMPUTE;
                end
            end
            COMPUTE: begin
                // e^2 is non-negative, so the saturating add clamps at the positive max.
                acc_d = sfp_add(acc_q, lane_sq);
                k_d   = k_q + KW'(1);
                if (k_q == KW'(output_units - 1)) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                    if (count_q == CW'(batch_size - 1)) begin
                        loss_d       = acc_q;
                        loss_valid_d = 1'b1;
                        acc_d        = '0;
                        count_d      = '0;
                    end else begin
                        count_d = count_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            k_q          <= '0;
            act_q        <= ACT_LINEAR;
            pred_q       <= '0;
            sum_q        <= '0;
            tgt_q        <= '0;
            grad_q       <= '0;
            acc_q        <= '0;
            loss_q       <= '0;
            loss_valid_q <= 1'b0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            act_q        <= act_d;
            pred_q       <= pred_d;
            sum_q        <= sum_d;
            tgt_q        <= tgt_d;
            grad_q       <= grad_d;
            acc_q        <= acc_d;
            loss_q       <= loss_d;
            loss_valid_q <= loss_valid_d;
            count_q      <= count_d;
        end
    end

    assign in_ready       = (state_q == IDLE);
    assign out_valid      = (state_q == HOLD);
    assign error_gradient = grad_q;
    assign loss           = loss_q;
    assign loss_valid     = loss_valid_q;
    assign sample_count   = count_q;
endmodule

// File: tb/tb_output_error_unit.sv
module tb_output_error_unit;
    import output_error_pkg::*;

    localparam int N  = 2;
    localparam int B  = 4;
    localparam int CW = $clog2(B + 1);

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    act_func        activation = ACT_LINEAR;
    sfp [N-1:0]     predictions = '0;
    sfp [N-1:0]     sums = '0;
    sfp [N-1:0]     targets = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    sfp [N-1:0]     error_gradient;
    logic           loss_valid;
    sfp             loss;
    logic [CW-1:0]  sample_count;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: running batch sum, sample count, last reported loss.
    int m_acc = 0;
    int m_count = 0;
    int m_loss = 0;
    bit m_lv = 1'b0;
    int cur_p[N];
    int cur_t[N];
    int exp_g[N];
    int last_lat;
    bit timed_out;

    output_error_unit #(.output_units(N), .batch_size(B)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .activation(activation), .predictions(predictions), .sums(sums), .targets(targets),
        .out_valid(out_valid), .out_ready(out_ready), .error_gradient(error_gradient),
        .loss_valid(loss_valid), .loss(loss), .sample_count(sample_count)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Real-valued Q8.8 rules expressed with integer arithmetic: clamp to 16-bit range,
    // product floored to a multiple of 1/256.
    function automatic int clamp(longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return int'(v);
    endfunction

    function automatic int fadd(int a, int b);
        return clamp(longint'(a) + longint'(b));
    endfunction

    function automatic int fneg(int a);
        return clamp(-longint'(a));
    endfunction

    function automatic int fmul(int a, int b);
        longint pr = longint'(a) * longint'(b);
        longint q = pr / 256;
        if (pr < 0 && (pr % 256) != 0) q = q - 1;
        return clamp(q);
    endfunction

    function automatic int model_grad(act_func a, int p, int t, int s);
        int e = fadd(p, fneg(t));
        case (a)
            ACT_SIGMOID: return fmul(fmul(e, p), fadd(256, fneg(p)));
            ACT_TANH:    return fmul(e, fadd(256, fneg(fmul(p, p))));
            ACT_RELU:    return (s >= 0) ? e : 0;
            default:     return e;
        endcase
    endfunction

    function automatic int model_sq(int p, int t);
        int e = fadd(p, fneg(t));
        return fmul(e, e);
    endfunction

    task automatic model_clear();
        m_acc = 0;
        m_count = 0;
        m_loss = 0;
        m_lv = 1'b0;
    endtask

    task automatic apply_reset();
        #1 rst = 1'b1;
        #2 rst = 1'b0;
        model_clear();
    endtask

    // Presents one sample, then waits (bounded) for out_valid.
    task automatic send(input act_func a, input int p[N], input int t[N], input int s[N]);
        int w = 0;
        timed_out = 1'b0;
        while (!in_ready && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        if (!in_ready) timed_out = 1'b1;
        activation = a;
        for (int i = 0; i < N; i++) begin
            predictions[i] = p[i][15:0];
            targets[i]     = t[i][15:0];
            sums[i]        = s[i][15:0];
            cur_p[i]       = p[i];
            cur_t[i]       = t[i];
            exp_g[i]       = model_grad(a, p[i], t[i], s[i]);
        end
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            predictions[i] = sfp'($urandom);
            targets[i]     = sfp'($urandom);
            sums[i]        = sfp'($urandom);
        end
        activation = act_func'($urandom_range(0, 3));
        last_lat = 0;
        while (!out_valid && last_lat < 20) begin
            @(posedge clk); #1;
            last_lat++;
        end
        if (!out_valid) timed_out = 1'b1;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) m_acc = fadd(m_acc, model_sq(cur_p[i], cur_t[i]));
        m_count++;
        m_lv = 1'b0;
        if (m_count == B) begin
            m_loss  = m_acc;
            m_acc   = 0;
            m_count = 0;
            m_lv    = 1'b1;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_clear();
        n_checks += 6;
        if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        if (loss_valid !== 1'b0) begin n_errors++; $display("FAIL reset_loss_valid: got %b expected 0", loss_valid); end
        if (loss !== sfp'(0)) begin n_errors++; $display("FAIL reset_loss: got %0d expected 0", loss); end
        if (sample_count !== '0) begin n_errors++; $display("FAIL reset_count: got %0d expected 0", sample_count); end
        if (error_gradient !== '0) begin n_errors++; $display("FAIL reset_grad: got %h expected 0", error_gradient); end
        $display("test_reset done");
    endtask

    task automatic test_sigmoid();
        int p[N], t[N], s[N];
        int want[N];
        p = '{192, 128}; t = '{256, 128}; s = '{0, 0}; want = '{-12, 0};
        send(ACT_SIGMOID, p, t, s);
        n_checks += 2;
        if (timed_out) begin n_errors++; $display("FAIL sig_timeout: got timeout expected out_valid"); end
        if (last_lat != N) begin n_errors++; $display("FAIL sig_latency: got %0d expected %0d", last_lat, N); end
        for (int i = 0; i < N; i++) begin
            n_checks += 2;
            if (int'(error_gradient[i]) != want[i]) begin n_errors++; $display("FAIL sig_grad[%0d]: got %0d expected %0d", i, error_gradient[i], want[i]); end
            if (int'(error_gradient[i]) != exp_g[i]) begin n_errors++; $display("FAIL sig_grad_model[%0d]: got %0d expected %0d", i, error_gradient[i], exp_g[i]); end
        end
        handshake();
        n_checks += 4;
        if (out_valid !== 1'b0) begin n_errors++; $display("FAIL sig_out_valid_drop: got %b expected 0", out_valid); end
        if (in_ready !== 1'b1) begin n_errors++; $display("FAIL sig_in_ready: got %b expected 1", in_ready); end
        if (int'(sample_count) != 1) begin n_errors++; $display("FAIL sig_count: got %0d expected 1", sample_count); end
        @(posedge clk); #1;
        if (int'(error_gradient[0]) != -12) begin n_errors++; $display("FAIL sig_grad_hold: got %0d expected -12", error_gradient[0]); end
        $display("test_sigmoid done: grad0=%0d grad1=%0d", error_gradient[0], error_gradient[1]);
    endtask

    task automatic test_tanh_relu();
        int p[N], t[N], s[N];
        int want[N];
        p = '{128, -128}; t = '{0, 0}; s = '{0, 0}; want = '{96, -96};
        send(ACT_TANH, p, t, s);
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if (int'(error_gradient[i]) != want[i]) begin n_errors++; $display("FAIL tanh_grad[%0d]: got %0d expected %0d", i, error_gradient[i], want[i]); end
        end
        handshake();
        $display("test_tanh sample done");
        p = '{0, 128}; t = '{64, 64}; s = '{-256, 128}; want = '{0, 64};
        send(ACT_RELU, p, t, s);
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if (int'(error_gradient[i]) != want[i]) begin n_errors++; $display("FAIL relu_grad[%0d]: got %0d expected %0d", i, error_gradient[i], want[i]); end
        end
        handshake();
        n_checks++;
        if (int'(sample_count) != 3) begin n_errors++; $display("FAIL relu_count: got %0d expected 3", sample_count); end
        $display("test_relu sample done");
    endtask

    task automatic test_backpressure();
        int p[N], t[N], s[N];
        p = '{300, -40}; t = '{100, 20}; s = '{0, 0};
        send(ACT_LINEAR, p, t, s);
        in_valid = 1'b1;
        predictions = {16'sh0123, 16'sh0456};
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            n_checks += 3;
            if (out_valid !== 1'b1) begin n_errors++; $display("FAIL bp_out_valid[%0d]: got %b expected 1", c, out_valid); end
            if (in_ready !== 1'b0) begin n_errors++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", c, in_ready); end
            if (int'(error_gradient[0]) != exp_g[0] || int'(error_gradient[1]) != exp_g[1]) begin
                n_errors++;
                $display("FAIL bp_grad_stable[%0d]: got %0d,%0d expected %0d,%0d", c, error_gradient[0], error_gradient[1], exp_g[0], exp_g[1]);
            end
        end
        handshake();
        in_valid = 1'b0;
        n_checks += 5;
        if (in_ready !== 1'b1) begin n_errors++; $display("FAIL bp_in_ready_after: got %b expected 1", in_ready); end
        if (loss_valid !== m_lv) begin n_errors++; $display("FAIL bp_loss_valid: got %b expected %b", loss_valid, m_lv); end
        if (int'(loss) != m_loss) begin n_errors++; $display("FAIL bp_loss: got %0d expected %0d", loss, m_loss); end
        if (int'(sample_count) != 0) begin n_errors++; $display("FAIL bp_count: got %0d expected 0", sample_count); end
        @(posedge clk); #1;
        if (loss_valid !== 1'b0) begin n_errors++; $display("FAIL bp_loss_pulse: got %b expected 0", loss_valid); end
        $display("test_backpressure done: loss=%0d", loss);
    endtask

    task automatic test_batch_loss();
        int p[N], t[N], s[N];
        int want_loss;
        apply_reset();
        for (int i = 0; i < 2 * B; i++) begin
            if (i < B) begin p = '{128 + 10 * i, 5 * i}; t = '{10 * i, 5 * i}; end
            else begin p = '{64, -i}; t = '{0, -64 - i}; end
            s = '{0, 0};
            send(ACT_LINEAR, p, t, s);
            handshake();
            want_loss = (i < B - 1) ? 0 : (i < 2 * B - 1) ? 256 : 128;
            n_checks += 4;
            if (int'(sample_count) != (i + 1) % B) begin n_errors++; $display("FAIL batch_count[%0d]: got %0d expected %0d", i, sample_count, (i + 1) % B); end
            if (loss_valid !== ((i % B) == B - 1)) begin n_errors++; $display("FAIL batch_loss_valid[%0d]: got %b expected %b", i, loss_valid, (i % B) == B - 1); end
            if (int'(loss) != want_loss) begin n_errors++; $display("FAIL batch_loss[%0d]: got %0d expected %0d", i, loss, want_loss); end
            if (int'(loss) != m_loss) begin n_errors++; $display("FAIL batch_loss_model[%0d]: got %0d expected %0d", i, loss, m_loss); end
            @(posedge clk); #1;
            n_checks++;
            if (loss_valid !== 1'b0) begin n_errors++; $display("FAIL batch_loss_pulse[%0d]: got %b expected 0", i, loss_valid); end
            $display("batch sample %0d: count=%0d loss=%0d", i, sample_count, loss);
        end
    endtask

    task automatic test_saturation();
        int p[N], t[N], s[N];
        apply_reset();
        p = '{16383, 16383}; t = '{0, 0}; s = '{0, 0};
        for (int i = 0; i < B; i++) begin
            send(ACT_LINEAR, p, t, s);
            n_checks++;
            if (int'(error_gradient[0]) != 16383) begin n_errors++; $display("FAIL sat_grad[%0d]: got %0d expected 16383", i, error_gradient[0]); end
            handshake();
        end
        n_checks += 2;
        if (int'(loss) != 32767) begin n_errors++; $display("FAIL sat_loss: got %0d expected 32767", loss); end
        if (loss_valid !== 1'b1) begin n_errors++; $display("FAIL sat_loss_valid: got %b expected 1", loss_valid); end
        $display("test_saturation done: loss=%0d", loss);
    endtask

    task automatic test_reset_mid_compute();
        int p[N], t[N], s[N];
        apply_reset();
        @(posedge clk); #1;
        activation = ACT_LINEAR;
        predictions = {16'sh0100, 16'sh0200};
        targets = '0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        #2 rst = 1'b1;
        #1;
        n_checks += 5;
        if (out_valid !== 1'b0) begin n_errors++; $display("FAIL mid_rst_out_valid: got %b expected 0", out_valid); end
        if (in_ready !== 1'b1) begin n_errors++; $display("FAIL mid_rst_in_ready: got %b expected 1", in_ready); end
        if (sample_count !== '0) begin n_errors++; $display("FAIL mid_rst_count: got %0d expected 0", sample_count); end
        if (loss !== sfp'(0)) begin n_errors++; $display("FAIL mid_rst_loss: got %0d expected 0", loss); end
        if (error_gradient !== '0) begin n_errors++; $display("FAIL mid_rst_grad: got %h expected 0", error_gradient); end
        #1 rst = 1'b0;
        model_clear();
        p = '{192, 128}; t = '{256, 128}; s = '{0, 0};
        send(ACT_SIGMOID, p, t, s);
        n_checks += 2;
        if (int'(error_gradient[0]) != -12) begin n_errors++; $display("FAIL mid_rst_regrad0: got %0d expected -12", error_gradient[0]); end
        if (int'(error_gradient[1]) != 0) begin n_errors++; $display("FAIL mid_rst_regrad1: got %0d expected 0", error_gradient[1]); end
        handshake();
        n_checks++;
        if (int'(sample_count) != 1) begin n_errors++; $display("FAIL mid_rst_count_after: got %0d expected 1", sample_count); end
        $display("test_reset_mid_compute done");
    endtask

    task automatic test_random();
        int p[N], t[N], s[N];
        act_func a;
        int stall;
        for (int it = 0; it < 40; it++) begin
            a = act_func'($urandom_range(0, 3));
            for (int i = 0; i < N; i++) begin
                p[i] = int'($urandom_range(0, 1200)) - 600;
                t[i] = int'($urandom_range(0, 1200)) - 600;
                s[i] = int'($urandom_range(0, 1200)) - 600;
            end
            send(a, p, t, s);
            n_checks += 2;
            if (timed_out) begin n_errors++; $display("FAIL rnd_timeout[%0d]: got timeout expected out_valid", it); end
            if (last_lat != N) begin n_errors++; $display("FAIL rnd_latency[%0d]: got %0d expected %0d", it, last_lat, N); end
            stall = int'($urandom_range(0, 2));
            repeat (stall) begin
                @(posedge clk); #1;
                n_checks++;
                if (out_valid !== 1'b1) begin n_errors++; $display("FAIL rnd_stall_valid[%0d]: got %b expected 1", it, out_valid); end
            end
            for (int i = 0; i < N; i++) begin
                n_checks++;
                if (int'(error_gradient[i]) != exp_g[i]) begin n_errors++; $display("FAIL rnd_grad[%0d][%0d]: got %0d expected %0d", it, i, error_gradient[i], exp_g[i]); end
            end
            handshake();
            n_checks += 3;
            if (int'(sample_count) != m_count) begin n_errors++; $display("FAIL rnd_count[%0d]: got %0d expected %0d", it, sample_count, m_count); end
            if (loss_valid !== m_lv) begin n_errors++; $display("FAIL rnd_loss_valid[%0d]: got %b expected %b", it, loss_valid, m_lv); end
            if (int'(loss) != m_loss) begin n_errors++; $display("FAIL rnd_loss[%0d]: got %0d expected %0d", it, loss, m_loss); end
            $display("rnd %0d: act=%0d g=%0d,%0d count=%0d loss=%0d", it, a, error_gradient[0], error_gradient[1], sample_count, loss);
        end
    endtask

    initial begin
        test_reset();
        test_sigmoid();
        test_tanh_relu();
        test_backpressure();
        test_batch_loss();
        test_saturation();
        test_reset_mid_compute();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
